// File: rtl/lsu_mem_access_if.sv
// Data-memory bus between the load/store unit and the memory port.
interface lsu_mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store access unit: MEM-stage request -> valid/ready data-memory bus
// transaction, with load alignment/extension and a per-access timeout.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    stall,
  lsu_mem_access_if.master        bus,
  output logic                    ld_valid,
  output logic [31:0]             ld_data,
  output logic [2:0]              ld_funct3,
  output logic                    st_done,
  output logic                    misalign_err,
  output logic                    bus_err
);

  localparam int unsigned       CNT_W    = 8;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept, reject, ld_fire, st_fire, tmo_fire;
  logic             f3_ok, aligned, req_ok;
  logic [3:0]       wstrb_nx;
  logic [31:0]      wdata_nx;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [31:0]      rd_shift;
  logic [31:0]      ld_align;

  // Request legality: funct3 encoding and natural alignment.
  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b0;
    if (req_we) begin
      f3_ok = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
    end else begin
      f3_ok = (req_funct3[1:0] == 2'b00) || (req_funct3[1:0] == 2'b01) ||
              (req_funct3 == 3'b010);
    end
    case (req_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (req_addr[0] == 1'b0);
      default: aligned = (req_addr[1:0] == 2'b00);
    endcase
    req_ok = f3_ok && aligned;
  end

  // Hold the MEM stage while busy or while a legal request is being taken.
  always_comb begin
    stall = (state != IDLE) || (req_valid && req_ok);
  end

  // Byte strobes and lane-replicated store data for the incoming request.
  always_comb begin
    wstrb_nx = 4'b0000;
    wdata_nx = 32'h0000_0000;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          wstrb_nx = 4'b0001 << req_addr[1:0];
          wdata_nx = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_nx = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_nx = {2{req_wdata[15:0]}};
        end
        default: begin
          wstrb_nx = 4'b1111;
          wdata_nx = req_wdata;
        end
      endcase
    end
  end

  // Right-align the read word by byte offset, then sign- or zero-fill.
  always_comb begin
    rd_shift = bus.mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_align = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_align = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_align = {24'h00_0000, rd_shift[7:0]};
      3'b101:  ld_align = {16'h0000, rd_shift[15:0]};
      default: ld_align = bus.mem_rdata;
    endcase
  end

  // Next-state, counter and completion events.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    reject   = 1'b0;
    ld_fire  = 1'b0;
    st_fire  = 1'b0;
    tmo_fire = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_ok) begin
            accept   = 1'b1;
            cnt_nx   = '0;
            state_nx = REQ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_nx = CNT_W'(cnt + CNT_W'(1));
        if (bus.mem_gnt && bus.mem_we) begin
          st_fire  = 1'b1;
          state_nx = IDLE;
        end else if (bus.mem_gnt && bus.mem_rvalid) begin
          ld_fire  = 1'b1;
          state_nx = IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo_fire = 1'b1;
          state_nx = IDLE;
        end else if (bus.mem_gnt) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        cnt_nx = CNT_W'(cnt + CNT_W'(1));
        if (bus.mem_rvalid) begin
          ld_fire  = 1'b1;
          state_nx = IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo_fire = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Bus drive, latched request fields and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0000_0000;
      bus.mem_wstrb <= 4'b0000;
      bus.mem_wdata <= 32'h0000_0000;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      ld_valid      <= 1'b0;
      ld_data       <= 32'h0000_0000;
      ld_funct3     <= 3'b000;
      st_done       <= 1'b0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      bus.mem_req  <= (state_nx == REQ);
      ld_valid     <= ld_fire;
      st_done      <= st_fire;
      misalign_err <= reject;
      bus_err      <= tmo_fire;
      if (accept) begin
        bus.mem_we    <= req_we;
        bus.mem_addr  <= {req_addr[31:2], 2'b00};
        bus.mem_wstrb <= wstrb_nx;
        bus.mem_wdata <= wdata_nx;
        f3_q          <= req_funct3;
        off_q         <= req_addr[1:0];
      end
      if (ld_fire) begin
        ld_data   <= ld_align;
        ld_funct3 <= f3_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: directed cases plus randomized
// accesses against a behavioural access/alignment model.
module tb_lsu_mem_access;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic        st_done;
  logic        misalign_err;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  lsu_mem_access_if bus ();

  lsu_mem_access #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .bus          (bus.master),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_funct3    (ld_funct3),
    .st_done      (st_done),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit known;
    int size;
    if (we) known = (f3 <= 3'd2);
    else    known = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    return known && ((int'(a[1:0]) % size) == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * int'(off));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_strb(input logic we, input logic [2:0] f3, input logic [1:0] off);
    if (!we) return 32'd0;
    case (f3[1:0])
      2'd0:    return 32'd1 << off;
      2'd1:    return 32'd3 << off;
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return 32'(wd[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // One access: g = cycles in REQ before gnt, r = cycles after gnt until rvalid.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
    bit legal, done;
    int e, last;
    legal = model_legal(we, f3, addr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    #1;
    check("stall_on_req", 32'(stall), 32'(legal));
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    #1;
    if (!legal) begin
      check("misalign_err", 32'(misalign_err), 32'd1);
      check("reject_no_req", 32'(bus.mem_req), 32'd0);
      check("reject_stall", 32'(stall), 32'd0);
      @(negedge clk);
      check("misalign_pulse_end", 32'(misalign_err), 32'd0);
      return;
    end
    e    = we ? g : g + r;
    done = (e <= int'(TMO) - 1);
    last = done ? e : int'(TMO) - 1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      check("mem_req", 32'(bus.mem_req), 32'(k <= g));
      check("stall_busy", 32'(stall), 32'd1);
      if (k == 0 || k == g) begin
        check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("mem_we", 32'(bus.mem_we), 32'(we));
        check("mem_wstrb", 32'(bus.mem_wstrb), model_strb(we, f3, addr[1:0]));
        if (we) check("mem_wdata", bus.mem_wdata, model_wdata(f3, wd));
      end
      bus.mem_gnt    = (k == g);
      bus.mem_rvalid = !we && (k == g + r);
      bus.mem_rdata  = (k == g + r) ? rd : $urandom;
    end
    @(negedge clk);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    #1;
    check("ld_valid", 32'(ld_valid), 32'(!we && done));
    check("st_done", 32'(st_done), 32'(we && done));
    check("bus_err", 32'(bus_err), 32'(!done));
    check("req_dropped", 32'(bus.mem_req), 32'd0);
    check("stall_done", 32'(stall), 32'd0);
    if (!we && done) begin
      check("ld_data", ld_data, model_load(f3, addr[1:0], rd));
      check("ld_funct3", 32'(ld_funct3), 32'(f3));
    end
    @(negedge clk);
    check("pulses_end", {29'd0, ld_valid, st_done, bus_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    bus.mem_gnt = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
    repeat (3) @(negedge clk);
    check("rst_outs", {25'd0, bus.mem_req, bus.mem_we, ld_valid, st_done, misalign_err, bus_err, stall}, 32'd0);
    check("rst_addr", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_wstrb), 32'd0);
    check("rst_ld", ld_data | 32'(ld_funct3), 32'd0);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;

    // LB, zero-wait bus
    run_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 0);
    // LHU, rvalid 3 cycles after gnt
    run_access(1'b0, 3'b101, 32'h0000_0022, 32'h0, 32'hBEEF_1234, 0, 3);
    // SB, gnt held off 2 cycles
    run_access(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 2, 0);
    // Rejects: misaligned LW, illegal funct3
    run_access(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
    run_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    // Timeout with gnt never asserted
    run_access(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 100, 0);
    run_access(1'b1, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'h0, 100, 0);

    // Reset while in WAIT, then a late rvalid must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #1;
    check("wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {28'd0, bus.mem_req, ld_valid, stall, bus_err}, 32'd0);
    check("midrst_data", ld_data | bus.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("late_rvalid", 32'(ld_valid), 32'd0);
    @(negedge clk);
    check("late_rvalid2", {30'd0, ld_valid, stall}, 32'd0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = (f3[1:0] == 2'd0) ? a[1:0] : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : 2'b00;
      run_access(we, f3, a, $urandom, $urandom, int'($urandom_range(4)), int'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
# lsu_mem_access

Load/store access unit between the MEM pipeline stage and the data-memory bus. It accepts one load or store per request, drives a valid/ready bus transaction with byte strobes, and waits for read data. Load data is right-aligned by byte offset and sign- or zero-filled. The result feeds the writeback load-extension stage together with its funct3. While a transaction is outstanding, the unit holds the pipeline with `stall`.

## Interface
- `TIMEOUT`, default 255: maximum cycles an access may spend in REQ+WAIT before it is aborted with `bus_err`. Legal range 2..255.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset. Assertion is asynchronous; release is synchronous to `clk` (synchroniser upstream).
- `req_valid` in 1: MEM stage presents an access.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I load/store funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `stall` out 1: hold the MEM stage (combinational).
- `mem_req` out 1: bus request valid.
- `mem_we` out 1: bus write enable.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte strobes.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: bus accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `ld_valid` out 1: one-cycle pulse; `ld_data` and `ld_funct3` are valid.
- `ld_data` out 32: aligned load data.
- `ld_funct3` out 3: funct3 of the completed load.
- `st_done` out 1: one-cycle pulse when a store is granted.
- `misalign_err` out 1: one-cycle pulse when a request is rejected.
- `bus_err` out 1: one-cycle pulse on timeout.

## Operation
- **FSM states:** IDLE, REQ, WAIT. Reset state is IDLE.
- **Reset values:** all registered outputs 0; `mem_*` outputs 0; counter 0.

- **IDLE with `req_valid`:** check the request.
  - Illegal funct3 is loads 011/110/111 and stores other than 000/001/010.
  - Misaligned is half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal or misaligned: `misalign_err`=1 next cycle, state stays IDLE, no bus activity.
  - Otherwise: latch `we`, `funct3`, `addr[1:0]`, word address, strobes and wdata; clear the counter; go to REQ.

- **Strobes and store data:**
  - Byte: `wstrb = 4'b0001 << off`, `wdata = {4{d[7:0]}}`.
  - Half: `wstrb = off[1] ? 4'b1100 : 4'b0011`, `wdata = {2{d[15:0]}}`.
  - Word: `wstrb = 4'b1111`, `wdata = d`.
  - Loads drive `wstrb = 4'b0000`.

- **REQ:** `mem_req`=1, and all `mem_*` outputs stay stable until `mem_gnt`.
  - Store granted: `st_done` pulses next cycle, go to IDLE.
  - Load granted with `mem_rvalid` in the same cycle: capture the data and go to IDLE.
  - Load granted otherwise: go to WAIT.

- **WAIT:** `mem_req`=0. On `mem_rvalid`, capture the data, pulse `ld_valid`, go to IDLE.
- **`mem_rvalid` outside REQ/WAIT:** ignored.

- **Load alignment:** `sh = mem_rdata >> (8*off)`.
  - Byte: `{{24{s}}, sh[7:0]}` with `s = sh[7]`.
  - Half: `{{16{s}}, sh[15:0]}` with `s = sh[15]`.
  - Unsigned variants (100, 101) use `s = 0`.
  - Word: `mem_rdata` unchanged.
  - `ld_funct3` is the latched funct3.

- **Timeout:** the counter increments every cycle in REQ or WAIT. If it equals `TIMEOUT`-1 and the access does not complete that cycle:
  - go to IDLE;
  - `bus_err`=1 next cycle;
  - no `ld_valid`/`st_done`;
  - drop `mem_req`.

- **Stall:** `stall = (state != IDLE) | (state == IDLE & req_valid & request legal)`.

- **Mid-operation reset:** `rst_n` low in any state returns the unit to IDLE and zeroes outputs immediately. A late `mem_rvalid` after reset is ignored.

## Timing
- Load, zero-wait bus: request accepted at cycle 0 (IDLE), then:
  - cycle 1: REQ with `mem_req`; `mem_gnt` and `mem_rvalid` arrive;
  - cycle 2: `ld_valid`.
  - Each extra gnt or rvalid wait cycle adds 1.
- Store: cycle 1 REQ + `mem_gnt`; cycle 2 `st_done`.
- The new request and MEM-stage advance share the cycle where `ld_valid`/`st_done` is high.
  - The cycle `ld_valid`/`st_done` is high, the state is IDLE.
  - `stall` is 0 unless a new legal request is present; such a request is accepted the same cycle.
- Back-to-back accesses: one access every 2 cycles minimum.
- All pulse outputs are exactly 1 cycle wide.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → all outputs 0, `stall`=0 while `req_valid`=0.
- **LB:**
  - Stimulus: addr 0x0000_1003, `mem_rdata` 0x8012_3456, zero-wait.
  - Bus side: `mem_addr` 0x0000_1000, `wstrb` 0000.
  - Result: 2 cycles after acceptance, `ld_valid` with `ld_data` 0xFFFF_FF80 and `ld_funct3` 000.
- **LHU:**
  - Stimulus: addr 0x22, rdata 0xBEEF_1234, `mem_rvalid` delayed 3 cycles after gnt.
  - Result: `ld_data` 0x0000_BEEF; `stall` high throughout the access.
- **SB:**
  - Stimulus: addr 0x101, wdata 0xAB, gnt held low 2 cycles.
  - Bus side: `mem_req` stable 3 cycles; `wstrb` 0010; `mem_wdata` 0xABAB_ABAB.
  - Result: `st_done` the cycle after gnt.
- **Rejected requests:**
  - LW at 0x102 → `misalign_err` pulse, `mem_req` never asserted, `stall`=0.
  - funct3 011 → same response.
- **Timeout and reset mid-access:**
  - `TIMEOUT`=4, gnt never asserted → `mem_req` high 4 cycles, then `bus_err` pulse, IDLE.
  - Reset in WAIT, then a late `mem_rvalid` arrives → no `ld_valid`.
